// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC stream packer.
// Holds the sample width, the capture state encoding and the
// per-sample offset-binary / two's-complement conversion function.
package adc_pkg;

  localparam int DATA_WIDTH = 14;
  localparam int OUT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Flipping the MSB of an offset-binary sample yields its two's-complement
  // value; sign extension only makes sense after that flip, so the raw
  // (offset-binary) path is zero-extended instead.
  function automatic logic [OUT_WIDTH-1:0] adc_convert(
    input logic [DATA_WIDTH-1:0] sample,
    input logic                  twos_comp
  );
    logic [DATA_WIDTH-1:0] s;
    s = sample;
    s[DATA_WIDTH-1] = sample[DATA_WIDTH-1] ^ twos_comp;
    if (twos_comp)
      return {{(OUT_WIDTH-DATA_WIDTH){s[DATA_WIDTH-1]}}, s};
    return {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, s};
  endfunction

endpackage

// File: rtl/adc_stream_packer_if.sv
// Sample-pair input and AXI4-Stream output bundle of the ADC stream packer.
// master: the packer (consumes ADC pairs, drives the stream);
// slave: the environment (drives ADC pairs and tready, observes the stream).
interface adc_stream_packer_if #(
  parameter int DATA_WIDTH = adc_pkg::DATA_WIDTH
);

  logic                  s_adc_valid;
  logic [DATA_WIDTH-1:0] s_adc_data_a;
  logic [DATA_WIDTH-1:0] s_adc_data_b;
  logic [31:0]           m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport master (
    input  s_adc_valid, s_adc_data_a, s_adc_data_b, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    output s_adc_valid, s_adc_data_a, s_adc_data_b, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rd_data shows the head entry (0 when empty).
// Ports: clk/rst, wr_en/wr_data, rd_en/rd_data, full/empty flags.
// Caller only writes when not full (or reading in the same cycle) and reads when not empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // address bits coincide.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Forcing zero while empty keeps the output clean after reset even though
  // the storage array itself is never cleared.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/adc_stream_packer.sv
// Packs ADC sample pairs into 32-bit AXI4-Stream words {chB, chA} with
// conversion, decimation, test pattern, output FIFO and drop accounting.
// Ports: m_axis_aclk/m_axis_areset, io (ADC pairs + stream), ctrl_* in, stat_* out.
module adc_stream_packer
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = adc_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 m_axis_aclk,
  input  logic                 m_axis_areset,
  adc_stream_packer_if.master  io,
  input  logic                 ctrl_enable,
  input  logic                 ctrl_twos_comp,
  input  logic                 ctrl_test_pattern,
  input  logic [3:0]           ctrl_decim,
  input  logic                 ctrl_clear,
  output logic                 stat_busy,
  output logic                 stat_overflow,
  output logic [CNT_WIDTH-1:0] stat_drop_count
);

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            decim_cnt;
  logic [DATA_WIDTH-1:0] pat_cnt;
  logic [DATA_WIDTH-1:0] smp_a;
  logic [DATA_WIDTH-1:0] smp_b;
  logic                  conv_vld;
  logic [31:0]           conv_dat;
  logic                  run;
  logic                  accept;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  drop;

  // Gating with ctrl_enable stops acceptance on the very edge that sees
  // enable low, before the state register has moved to DRAIN.
  assign run    = (state == RUN) && ctrl_enable;
  assign accept = run && io.s_adc_valid && (decim_cnt == 4'd0);

  assign smp_a = ctrl_test_pattern ? pat_cnt  : io.s_adc_data_a;
  assign smp_b = ctrl_test_pattern ? ~pat_cnt : io.s_adc_data_b;

  assign fifo_rd = io.m_axis_tvalid && io.m_axis_tready;
  // A full FIFO that is being read this cycle frees the slot being written.
  assign fifo_wr = conv_vld && (!fifo_full || fifo_rd);
  assign drop    = conv_vld && fifo_full && !fifo_rd;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_enable) state_nxt = RUN;
      RUN:     if (!ctrl_enable) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !conv_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      decim_cnt <= '0;
      pat_cnt   <= '0;
      conv_vld  <= 1'b0;
      conv_dat  <= '0;
    end else begin
      conv_vld <= accept;
      if (accept)
        conv_dat <= {adc_convert(smp_b, ctrl_twos_comp), adc_convert(smp_a, ctrl_twos_comp)};
      // Holding both counters at zero outside RUN makes every entry into
      // RUN start from a clean decimation phase and pattern value.
      if (state != RUN) begin
        decim_cnt <= '0;
        pat_cnt   <= '0;
      end else if (run && io.s_adc_valid) begin
        decim_cnt <= (decim_cnt >= ctrl_decim) ? 4'd0 : decim_cnt + 4'd1;
        if (accept) pat_cnt <= pat_cnt + DATA_WIDTH'(1);
      end
    end
  end

  // Clear takes priority over a drop landing in the same cycle.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset || ctrl_clear) begin
      stat_overflow   <= 1'b0;
      stat_drop_count <= '0;
    end else if (drop) begin
      stat_overflow <= 1'b1;
      if (stat_drop_count != '1) stat_drop_count <= stat_drop_count + CNT_WIDTH'(1);
    end
  end

  assign stat_busy        = (state != IDLE);
  assign io.m_axis_tvalid = !fifo_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (m_axis_aclk),
    .rst     (m_axis_areset),
    .wr_en   (fifo_wr),
    .wr_data (conv_dat),
    .rd_en   (fifo_rd),
    .rd_data (io.m_axis_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_adc_stream_packer.sv
// Randomized bench for adc_stream_packer with a queue-based reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_adc_stream_packer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, twos, tp, clear;
  logic [3:0]  decim;
  logic        busy, ovf;
  logic [15:0] drop_count;

  adc_stream_packer_if #(.DATA_WIDTH(14)) bus ();

  adc_stream_packer #(
    .DATA_WIDTH (14),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (16)
  ) dut (
    .m_axis_aclk       (clk),
    .m_axis_areset     (rst),
    .io                (bus.master),
    .ctrl_enable       (en),
    .ctrl_twos_comp    (twos),
    .ctrl_test_pattern (tp),
    .ctrl_decim        (decim),
    .ctrl_clear        (clear),
    .stat_busy         (busy),
    .stat_overflow     (ovf),
    .stat_drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;
  bit checking = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Offset binary to two's complement is simply "subtract mid-scale".
  function automatic logic [15:0] ref_conv(input logic [13:0] s, input bit tc);
    int v;
    if (!tc) return {2'b00, s};
    v = int'(s) - 8192;
    return v[15:0];
  endfunction

  logic [31:0] q[$];
  bit          slot_v;
  logic [31:0] slot_w;
  int          mode;      // 0 idle, 1 run, 2 drain
  int          nvalid;    // valid pairs seen since entering run
  int          nacc;      // pairs accepted since entering run
  bit          m_ovf;
  int          m_drops;

  always @(posedge clk) begin : model
    bit          rd, full, was_empty, was_slot;
    logic [13:0] a, b;
    if (rst) begin
      q.delete();
      slot_v  = 0;
      mode    = 0;
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      was_empty = (q.size() == 0);
      was_slot  = slot_v;
      rd        = (q.size() > 0) && bus.m_axis_tready;
      full      = (q.size() == DEPTH);
      if (rd) void'(q.pop_front());
      if (slot_v) begin
        if (!full || rd) q.push_back(slot_w);
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (clear) begin
        m_ovf   = 0;
        m_drops = 0;
      end
      slot_v = 0;
      case (mode)
        0: if (en) begin
          mode   = 1;
          nvalid = 0;
          nacc   = 0;
        end
        1: if (!en) mode = 2;
           else if (bus.s_adc_valid) begin
             if (nvalid % (int'(decim) + 1) == 0) begin
               if (tp) begin
                 a = nacc[13:0];
                 b = ~a;
               end else begin
                 a = bus.s_adc_data_a;
                 b = bus.s_adc_data_b;
               end
               slot_v = 1;
               slot_w = {ref_conv(b, twos), ref_conv(a, twos)};
               nacc++;
             end
             nvalid++;
           end
        default: if (was_empty && !was_slot) mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("tvalid", {31'd0, bus.m_axis_tvalid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("tdata", bus.m_axis_tdata, q[0]);
      chk("busy", {31'd0, busy}, {31'd0, mode != 0});
      chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
      chk("drop_count", {16'd0, drop_count}, m_drops);
    end
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) n_hs++;
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v);
    bus.s_adc_valid  = v;
    bus.s_adc_data_a = 14'($urandom_range(0, 16383));
    bus.s_adc_data_b = 14'($urandom_range(0, 16383));
    @(negedge clk);
  endtask

  task automatic step_ab(input logic [13:0] a, input logic [13:0] b);
    bus.s_adc_valid  = 1'b1;
    bus.s_adc_data_a = a;
    bus.s_adc_data_b = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  int hs0;

  initial begin
    rst = 1; en = 0; twos = 0; tp = 0; clear = 0; decim = 0;
    bus.s_adc_valid = 0; bus.s_adc_data_a = 0; bus.s_adc_data_b = 0;
    bus.m_axis_tready = 0;
    repeat (3) @(negedge clk);
    checking = 1;
    chk("rst_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
    chk("rst_tdata", bus.m_axis_tdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_drops", {16'd0, drop_count}, 32'd0);
    rst = 0;

    // Normal conversion.
    twos = 1; bus.m_axis_tready = 1; en = 1;
    step(0);
    step_ab(14'h2000, 14'h1FFF);
    step(0);
    chk("first_word", bus.m_axis_tdata, 32'hFFFF_0000);
    for (int i = 0; i < 30; i++) step($urandom_range(0, 1) == 1);
    twos = 0;
    for (int i = 0; i < 20; i++) step(1);
    en = 0; idle(6);

    // Test pattern with decimation by 4.
    twos = 1; tp = 1; decim = 4'd3; en = 1;
    step(0);
    hs0 = n_hs;
    for (int i = 0; i < 16; i++) step(1);
    en = 0; idle(6);
    chk("tp_words", n_hs - hs0, 32'd4);
    tp = 0; decim = 0;

    // Back-pressure and overflow.
    clear = 1; step(0); clear = 0;
    bus.m_axis_tready = 0; en = 1;
    step(0);
    for (int i = 0; i < 20; i++) step(1);
    idle(2);
    chk("bp_drops", {16'd0, drop_count}, 32'd4);
    chk("bp_ovf", {31'd0, ovf}, 32'd1);
    bus.m_axis_tready = 1;
    idle(20);
    clear = 1; step(0); clear = 0;
    chk("clr_ovf", {31'd0, ovf}, 32'd0);
    chk("clr_drops", {16'd0, drop_count}, 32'd0);

    // Disable and drain, with enable toggling during drain.
    bus.m_axis_tready = 0;
    hs0 = n_hs;
    for (int i = 0; i < 10; i++) step(1);
    idle(2);
    en = 0; bus.m_axis_tready = 1;
    step(0);
    en = 1; idle(3);
    en = 0; idle(15);
    chk("drain_words", n_hs - hs0, 32'd10);

    // Full FIFO with a simultaneous read, then reset mid-burst.
    en = 1; bus.m_axis_tready = 0;
    step(0);
    for (int i = 0; i < 16; i++) step(1);
    idle(2);
    step(1);
    bus.m_axis_tready = 1;
    step(0);
    bus.m_axis_tready = 0;
    idle(2);
    chk("full_rd_drops", {16'd0, drop_count}, 32'd0);
    bus.m_axis_tready = 1; idle(8);
    bus.m_axis_tready = 0; en = 0;
    idle(1);
    rst = 1; step(0);
    chk("rst_mid_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
    rst = 0; step(0);
    chk("post_rst_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if (mode == 0 && !en) decim = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) en = ~en;
      bus.m_axis_tready = ($urandom_range(0, 9) < 6);
      twos  = $urandom_range(0, 1) == 1;
      tp    = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 3) != 0);
    end
    clear = 0; en = 0; bus.m_axis_tready = 1;
    idle(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
